// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - CHANNELS:1 valid/ready stream mux, round-robin or fixed priority, one-entry output register
module mux_rr_stream #(
    parameter int N           = 5,
    parameter int CHANNELS    = 4,
    parameter int ROUND_ROBIN = 1,
    parameter int SEL_W       = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    output logic [N-1:0]          out_data,
    output logic [SEL_W-1:0]      out_channel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_found;
    logic             load_en;
    logic             accept;
    int               idx;

    // Search starts at ptr and wraps explicitly so non-power-of-two CHANNELS works.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_found && in_valid[idx]) begin
                grant_found = 1'b1;
                grant       = SEL_W'(idx);
            end
        end
    end

    assign load_en = !out_valid || out_ready;
    // Gating with rst keeps producers from seeing a handshake that reset will discard.
    assign accept  = rst && grant_found && load_en;

    always_comb begin
        in_ready = '0;
        if (accept) in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            ptr         <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= in_data[int'(grant)*N +: N];
            out_channel <= grant;
            if (ROUND_ROBIN != 0)
                ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + SEL_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb/tb_mux_rr_stream.sv - randomized and directed self-check of mux_rr_stream against a queue-free behavioural model
module tb_mux_rr_stream;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    logic out_ready;

    always #5 clk = ~clk;

    // dut 0: 4 channels round-robin, dut 1: 3 channels round-robin, dut 2: 4 channels fixed
    logic [3:0] vm [NDUT];
    logic [4:0] dm [NDUT][4];

    logic [19:0] in_data_a, in_data_c;
    logic [14:0] in_data_b;
    logic [3:0]  in_ready_a, in_ready_c;
    logic [2:0]  in_ready_b;
    logic [4:0]  out_data_a, out_data_b, out_data_c;
    logic [1:0]  out_channel_a, out_channel_b, out_channel_c;
    logic        out_valid_a, out_valid_b, out_valid_c;

    assign in_data_a = {dm[0][3], dm[0][2], dm[0][1], dm[0][0]};
    assign in_data_b = {dm[1][2], dm[1][1], dm[1][0]};
    assign in_data_c = {dm[2][3], dm[2][2], dm[2][1], dm[2][0]};

    mux_rr_stream #(.N(5), .CHANNELS(4), .ROUND_ROBIN(1)) u_rr4 (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(vm[0]), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_channel(out_channel_a), .out_valid(out_valid_a), .out_ready(out_ready));

    mux_rr_stream #(.N(5), .CHANNELS(3), .ROUND_ROBIN(1)) u_rr3 (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(vm[1][2:0]), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_channel(out_channel_b), .out_valid(out_valid_b), .out_ready(out_ready));

    mux_rr_stream #(.N(5), .CHANNELS(4), .ROUND_ROBIN(0)) u_fp4 (
        .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(vm[2]), .in_ready(in_ready_c),
        .out_data(out_data_c), .out_channel(out_channel_c), .out_valid(out_valid_c), .out_ready(out_ready));

    logic [3:0] obs_rdy [NDUT];
    logic [4:0] obs_d   [NDUT];
    logic [1:0] obs_c   [NDUT];
    logic       obs_v   [NDUT];
    assign obs_rdy[0] = in_ready_a;  assign obs_rdy[1] = {1'b0, in_ready_b};  assign obs_rdy[2] = in_ready_c;
    assign obs_d[0] = out_data_a;    assign obs_d[1] = out_data_b;            assign obs_d[2] = out_data_c;
    assign obs_c[0] = out_channel_a; assign obs_c[1] = out_channel_b;         assign obs_c[2] = out_channel_c;
    assign obs_v[0] = out_valid_a;   assign obs_v[1] = out_valid_b;           assign obs_v[2] = out_valid_c;

    int nch [NDUT] = '{4, 3, 4};
    bit rr  [NDUT] = '{1'b1, 1'b1, 1'b0};

    // Reference state: what the output stage should hold and where the next search starts.
    bit         m_v [NDUT];
    logic [4:0] m_d [NDUT];
    int         m_c [NDUT];
    int         m_p [NDUT];
    logic [3:0] exp_rdy [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int find_grant(input logic [3:0] v, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic step();
        int g [NDUT];
        bit load;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            g[d] = find_grant(vm[d], m_p[d], nch[d]);
            load = !m_v[d] || out_ready;
            exp_rdy[d] = (rst && load && g[d] >= 0) ? 4'(1 << g[d]) : 4'b0;
            check($sformatf("in_ready[%0d]", d), 32'(obs_rdy[d]), 32'(exp_rdy[d]));
        end
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            if (!rst) begin
                m_v[d] = 0; m_d[d] = '0; m_c[d] = 0; m_p[d] = 0;
            end else if (exp_rdy[d] != 0) begin
                m_v[d] = 1; m_d[d] = dm[d][g[d]]; m_c[d] = g[d];
                if (rr[d]) m_p[d] = (g[d] + 1) % nch[d];
            end else if (out_ready) begin
                m_v[d] = 0;
            end
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("out_valid[%0d]", d), 32'(obs_v[d]), 32'(m_v[d]));
            check($sformatf("out_channel[%0d]", d), 32'(obs_c[d]), 32'(m_c[d]));
            check($sformatf("out_data[%0d]", d), 32'(obs_d[d]), 32'(m_d[d]));
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            m_v[d] = 0; m_d[d] = '0; m_c[d] = 0; m_p[d] = 0; exp_rdy[d] = '0;
            for (int i = 0; i < 4; i++) dm[d][i] = 5'(10 + i);
        end
        vm[0] = 4'b1111; vm[1] = 4'b0111; vm[2] = 4'b0101;
        out_ready = 1'b1;
        rst = 1'b0;

        // reset with every channel requesting
        step();
        step();
        check("reset_ready", 32'(in_ready_a), 32'h0);
        rst = 1'b1;

        // round-robin sweep, first grant after reset is channel 0
        for (int k = 0; k < 6; k++) begin
            step();
            check("sweep_ch", 32'(out_channel_a), 32'(k % 4));
            check("sweep_data", 32'(out_data_a), 32'(10 + k % 4));
            check("fixed_ch0", 32'(out_channel_c), 32'h0);
        end

        // backpressure: ptr is 2 now
        dm[0][2] = 5'h1F;
        step();
        check("bp_first_ch", 32'(out_channel_a), 32'h2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_data", 32'(out_data_a), 32'h1F);
            check("bp_hold_ch", 32'(out_channel_a), 32'h2);
            check("bp_ready_low", 32'(in_ready_a), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready_a), 32'h8);
        step();
        check("bp_release_ch", 32'(out_channel_a), 32'h3);

        // sparse channels 3 and 1, starting with ptr=2
        vm[0] = 4'b0010;
        step();
        vm[0] = 4'b1010;
        vm[2] = 4'b0100;
        step();
        check("sparse_ch3", 32'(out_channel_a), 32'h3);
        check("fixed_drop0", 32'(out_channel_c), 32'h2);
        step();
        check("sparse_ch1", 32'(out_channel_a), 32'h1);
        step();
        check("sparse_ch3_again", 32'(out_channel_a), 32'h3);

        // reset mid-operation with a stalled beat and ptr=3
        vm[0] = 4'b0100;
        step();
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("midrst_valid", 32'(out_valid_a), 32'h0);
        rst = 1'b1;
        out_ready = 1'b1;
        vm[0] = 4'b1111;
        step();
        check("midrst_grant", 32'(out_channel_a), 32'h0);

        // randomized traffic; producers hold a beat while it waits
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < NDUT; d++) begin
                for (int i = 0; i < nch[d]; i++) begin
                    if (!(vm[d][i] && !exp_rdy[d][i])) begin
                        vm[d][i] = ($urandom % 3) != 0;
                        dm[d][i] = 5'($urandom);
                    end
                end
            end
            out_ready = ($urandom % 4) != 0;
            rst = ($urandom % 64) != 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised successor to the 4:1 combinational mux.
- Selects one of CHANNELS valid/ready input streams using either round-robin or fixed-priority arbitration.
- Registers the selected beat together with its source channel index into a one-entry output stage.
- Sits between multiple producers (e.g. register-file read ports, peripheral request queues) and a single shared consumer.

Parameters:
- N, 5: data width of each channel, in bits.
- CHANNELS, 4: number of input channels. Legal range is 2..32; any value, not only powers of two.
- ROUND_ROBIN, 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the lowest index wins.
- SEL_W, $clog2(CHANNELS): width of the channel index. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 at a rising clk edge resets).
- in_data  input  CHANNELS*N  packed channel data; channel i occupies bits [i*N +: N].
- in_valid  input  CHANNELS  bit i set: channel i presents a beat.
- in_ready  output  CHANNELS  bit i set: channel i's beat is accepted this cycle.
- out_data  output  N  registered selected data.
- out_channel  output  SEL_W  registered index of the source channel of out_data.
- out_valid  output  1  output stage holds a beat.
- out_ready  input  1  consumer accepts the beat this cycle.

Behaviour:
- Reset (rst=0 at edge): out_valid=0, out_data=0, out_channel=0, priority pointer ptr=0.
  - Reset overrides any simultaneous handshake.
  - A beat pending mid-operation is discarded, not delivered.
- load_en = !out_valid || out_ready. The output stage accepts a new beat when it is empty or is draining this cycle.
- Grant (combinational):
  - Round-robin: search channels ptr, ptr+1, ..., wrapping modulo CHANNELS. The first channel with in_valid=1 wins.
  - Fixed priority: search from channel 0 upward.
- in_ready[g] = load_en for the granted channel g only. All other in_ready bits are 0.
  - If no in_valid is set, all in_ready bits are 0.
  - in_ready may depend combinationally on in_valid and out_ready. There is no combinational path from in_data.
- Accept (in_valid[g] && in_ready[g]) at an edge:
  - out_data <= channel g data, out_channel <= g, out_valid <= 1.
  - Round-robin: ptr <= (g+1) mod CHANNELS. When g = CHANNELS-1, ptr wraps to 0, including for non-power-of-two CHANNELS.
- Drain without refill: out_valid && out_ready with no accept gives out_valid <= 0. out_data and out_channel hold their last values.
- Stall: while out_valid && !out_ready, out_data and out_channel are stable, all in_ready bits are 0, and ptr is unchanged.
- Drain and refill in the same cycle: the new beat is loaded and out_valid stays 1. Full throughput is one beat per cycle.
- Latency: a beat accepted at edge k appears on out_* after edge k; zero bubbles.
- ptr changes only on an accept. Idle cycles do not advance it.
- Fairness (round-robin): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,CHANNELS-1,0,... No channel waits more than CHANNELS-1 accepts.
- Fixed mode: ptr is held at 0. A continuously valid channel 0 starves all others; this is the intended behaviour.
- Producer rule: input channels must hold data stable while valid and not ready. The block does not check this.

Test Plan:
- Reset: drive rst=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_channel=0, in_ready=0 during reset. The first accept after release is channel 0.
- Round-robin sweep (CHANNELS=4, N=5): data = 5'd10, 11, 12, 13; all valid; out_ready=1 -> out_channel sequence 0,1,2,3,0,1 on consecutive cycles with matching out_data. out_valid stays high.
- Backpressure: out_ready=0 for 3 cycles after the first beat (channel 2, data 5'h1F) -> out_data=5'h1F and out_channel=2 held, in_ready=4'b0000. When out_ready rises, the next grant is channel 3 in the same cycle.
- Sparse and wrap: only channels 3 and 1 valid with ptr=2 -> grant 3, then ptr=0 gives grant 1, then ptr=2 gives grant 3. Also run CHANNELS=3 and confirm a grant on channel 2 wraps ptr to 0.
- Fixed priority (ROUND_ROBIN=0): channels 0 and 2 continuously valid -> channel 0 is granted every cycle. Drop channel 0's valid and channel 2 is granted the next cycle.
- Reset mid-operation: out_valid=1, out_ready=0, ptr=3, then rst=0 for one edge -> out_valid=0 and ptr=0. The next grant with all channels valid is channel 0.
